sipo_arbiter: RTL and testbench



---
 rtl/sipo_arbiter_if.sv | 31 +++
 rtl/sipo_arbiter.sv | 139 +++++++++++++
 tb/tb_sipo_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_arbiter_if.sv
// Bus bundle between the round-robin sipo arbiter, its serial requesters,
// the shared sipo deserializer and the word consumer.
interface sipo_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SIZE    = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ser_in;
  logic [NUM_REQ-1:0] gnt;
  logic               sipo_in;
  logic               sipo_en;
  logic [SIZE-1:0]    sipo_out;
  logic               sipo_done;
  logic [SIZE-1:0]    out_data;
  logic [IDX_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;
  logic               err;

  modport master (
    input  req, ser_in, sipo_out, sipo_done, out_ready,
    output gnt, sipo_in, sipo_en, out_data, out_src, out_valid, err
  );

  modport slave (
    output req, ser_in, sipo_out, sipo_done, out_ready,
    input  gnt, sipo_in, sipo_en, out_data, out_src, out_valid, err
  );
endinterface

// File: rtl/sipo_arbiter.sv
// Round-robin arbiter sharing one sipo deserializer among NUM_REQ serial requesters.
// Sequences grant/shift/capture per frame and holds the word behind valid/ready.
module sipo_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SIZE    = 8
) (
  input logic            clk,
  input logic            reset,
  sipo_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(SIZE) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, GRANT, SHIFT, CAPTURE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               sipo_en_q, sipo_en_d;
  logic [SIZE-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   next_ptr;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned k;
    logic        found;
    k     = 0;
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(rr_ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && bus.req[IDX_W'(k)]) begin
        found = 1'b1;
        pick  = IDX_W'(k);
      end
    end
  end

  assign next_ptr = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    bit_cnt_d   = bit_cnt_q;
    gnt_d       = '0;
    sipo_en_d   = 1'b0;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = pick;
          gnt_d   = NUM_REQ'(1) << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        gnt_d     = NUM_REQ'(1) << sel_q;
        sipo_en_d = 1'b1;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        // Registered grant/enable drop together with the last shifted bit
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = CAPTURE;
        end else begin
          gnt_d     = NUM_REQ'(1) << sel_q;
          sipo_en_d = 1'b1;
        end
      end
      CAPTURE: begin
        rr_ptr_d = next_ptr;
        if (bus.sipo_done) begin
          out_data_d  = bus.sipo_out;
          out_src_d   = sel_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
        else               out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      bit_cnt_q   <= '0;
      gnt_q       <= '0;
      sipo_en_q   <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      gnt_q       <= gnt_d;
      sipo_en_q   <= sipo_en_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Serial bit passes straight through so sipo samples it at the edge ending the SHIFT cycle
  assign bus.sipo_in   = (state_q == SHIFT) ? bus.ser_in[sel_q] : 1'b0;
  assign bus.gnt       = gnt_q;
  assign bus.sipo_en   = sipo_en_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_sipo_arbiter.sv
// Self-checking bench: frame-timeline reference model plus directed and random stimulus,
// with a bench-side LSB-first sipo attached to the arbiter.
module tb_sipo_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SIZE    = 8;
  localparam int NR = NUM_REQ;
  localparam int SZ = SIZE;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sipo_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) bus ();
  sipo_arbiter #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  int  n_vec = 0;
  int  n_bad = 0;
  bit  check_en   = 1'b0;
  bit  kill_done  = 1'b0;
  bit  rand_words = 1'b0;
  logic [SIZE-1:0] tx_word [NUM_REQ];
  int  gc [NUM_REQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Attached sipo: LSB-first shift, done one cycle after the SIZE-th enable
  logic [SIZE-1:0] sipo_sr;
  int              sipo_cnt;
  logic            sipo_done_r;
  always @(posedge clk) begin
    if (reset) begin
      sipo_sr     <= '0;
      sipo_cnt    <= 0;
      sipo_done_r <= 1'b0;
    end else begin
      sipo_done_r <= 1'b0;
      if (bus.sipo_en) begin
        sipo_sr <= {bus.sipo_in, sipo_sr[SIZE-1:1]};
        if (sipo_cnt == SZ - 1) begin
          sipo_cnt    <= 0;
          sipo_done_r <= 1'b1;
        end else begin
          sipo_cnt <= sipo_cnt + 1;
        end
      end
    end
  end
  assign bus.sipo_out  = sipo_sr;
  assign bus.sipo_done = sipo_done_r & ~kill_done;

  // Requesters: idle line is noise; bit k is presented k+1 cycles after the grant appears
  always @(posedge clk) begin
    logic [NUM_REQ-1:0] s;
    #1;
    s = '0;
    for (int i = 0; i < NR; i++) begin
      if (bus.gnt[i]) gc[i] = gc[i] + 1;
      else begin
        if (gc[i] != 0 && rand_words) tx_word[i] = SIZE'($urandom);
        gc[i] = 0;
      end
      if (gc[i] >= 2 && gc[i] <= SZ + 1) s[i] = tx_word[i][gc[i]-2];
      else                               s[i] = 1'($urandom);
    end
    bus.ser_in = s;
  end

  // Reference model: phase -1 idle, 0 grant setup, 1..SIZE bit slots, SIZE+1 capture
  int              m_phase   = -1;
  bit              m_hold    = 1'b0;
  int              m_src     = 0;
  int              m_rr      = 0;
  logic [SIZE-1:0] m_word    = '0;
  logic [SIZE-1:0] m_data    = '0;
  int              m_out_src = 0;
  bit              m_err     = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = -1; m_hold = 1'b0; m_rr = 0;
      m_data = '0; m_out_src = 0; m_err = 1'b0;
    end else if (m_hold) begin
      if (bus.out_ready) m_hold = 1'b0;
    end else if (m_phase < 0) begin
      if (bus.req != '0) begin
        for (int i = 0; i < NR; i++) begin
          if (bus.req[(m_rr + i) % NR]) begin
            m_src = (m_rr + i) % NR;
            break;
          end
        end
        m_phase = 0;
      end
    end else if (m_phase <= SZ) begin
      if (m_phase >= 1) m_word[m_phase-1] = bus.ser_in[m_src];
      m_phase++;
    end else begin
      m_rr = (m_src + 1) % NR;
      if (kill_done) m_err = 1'b1;
      else begin
        m_data    = m_word;
        m_out_src = m_src;
        m_hold    = 1'b1;
      end
      m_phase = -1;
    end
  end

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    bit                 shifting;
    if (check_en) begin
      shifting = (m_phase >= 1 && m_phase <= SZ);
      eg = (m_phase >= 0 && m_phase <= SZ) ? (NUM_REQ'(1) << m_src) : '0;
      chk("gnt",       32'(bus.gnt),       32'(eg));
      chk("sipo_en",   32'(bus.sipo_en),   32'(shifting));
      chk("sipo_in",   32'(bus.sipo_in),   shifting ? 32'(bus.ser_in[m_src]) : 32'(0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_src",   32'(bus.out_src),   32'(m_out_src));
      chk("err",       32'(bus.err),       32'(m_err));
    end
  end

  task automatic run_frame(input logic [NUM_REQ-1:0] r, input int drop_at, input string tag,
                           output int lat, output int gcnt, output int ecnt);
    bit seen;
    seen = 1'b0;
    bus.req = r;
    lat = 0; gcnt = 0; ecnt = 0;
    while (!seen && lat < 60) begin
      cyc();
      lat++;
      if (lat == drop_at) bus.req = '0;
      if (bus.gnt != '0) gcnt++;
      if (bus.sipo_en)   ecnt++;
      if (bus.out_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'(1));
  endtask

  task automatic drain();
    bus.req = '0; bus.out_ready = 1'b1; kill_done = 1'b0;
    repeat (SIZE + 8) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
  endtask

  initial begin
    int lat, gcnt, ecnt, bad, gbad, vbad, vcnt;
    logic [SIZE-1:0]  d0;
    logic [31:0]      s0;
    bus.req = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < NR; i++) tx_word[i] = '0;

    reset = 1'b1; cyc(); check_en = 1'b1; cyc(); reset = 1'b0;
    chk("rst_gnt",   32'(bus.gnt),       32'(0));
    chk("rst_en",    32'(bus.sipo_en),   32'(0));
    chk("rst_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_err",   32'(bus.err),       32'(0));

    // Single frame from requester 1
    tx_word[1] = 8'h4D;
    run_frame(4'b0010, -1, "sf", lat, gcnt, ecnt);
    chk("sf_latency", 32'(lat), 32'(11));
    chk("sf_data",    32'(bus.out_data), 32'h4D);
    chk("sf_src",     32'(bus.out_src),  32'(1));
    chk("sf_gnt_cyc", 32'(gcnt), 32'(9));
    chk("sf_en_cyc",  32'(ecnt), 32'(8));
    drain();

    // Round-robin with all requesting
    do_reset();
    for (int i = 0; i < NR; i++) tx_word[i] = 8'hA0 + 8'(i);
    bus.out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame(4'b1111, -1, "rr", lat, gcnt, ecnt);
      chk("rr_src",  32'(bus.out_src), 32'(f % NR));
      chk("rr_data", 32'(bus.out_data), 32'(8'hA0 + 8'(f % NR)));
    end
    bus.req = '0;
    drain();

    // Backpressure: hold the word for 20 cycles
    tx_word[2] = 8'h96;
    bus.out_ready = 1'b0;
    run_frame(4'b0100, -1, "bp", lat, gcnt, ecnt);
    d0 = bus.out_data; s0 = 32'(bus.out_src);
    chk("bp_src",  s0, 32'(2));
    chk("bp_data", 32'(d0), 32'h96);
    bad = 0; gbad = 0; vbad = 0;
    repeat (20) begin
      cyc();
      if (bus.out_data !== d0 || 32'(bus.out_src) !== s0) bad++;
      if (bus.gnt != '0) gbad++;
      if (!bus.out_valid) vbad++;
    end
    chk("bp_stable", 32'(bad),  32'(0));
    chk("bp_no_gnt", 32'(gbad), 32'(0));
    chk("bp_valid",  32'(vbad), 32'(0));
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_idle_valid", 32'(bus.out_valid), 32'(0));
    chk("bp_idle_gnt",   32'(bus.gnt),       32'(0));
    cyc();
    chk("bp_regrant", 32'(bus.gnt), 32'(4'b0100));
    drain();

    // Reset during the 4th SHIFT cycle
    tx_word[0] = 8'hFF;
    bus.req = 4'b0001;
    repeat (5) cyc();
    reset = 1'b1; bus.req = '0;
    cyc();
    reset = 1'b0;
    chk("mr_gnt",   32'(bus.gnt),       32'(0));
    chk("mr_en",    32'(bus.sipo_en),   32'(0));
    chk("mr_valid", 32'(bus.out_valid), 32'(0));
    chk("mr_data",  32'(bus.out_data),  32'(0));
    chk("mr_src",   32'(bus.out_src),   32'(0));
    vcnt = 0;
    repeat (15) begin cyc(); if (bus.out_valid) vcnt++; end
    chk("mr_no_valid", 32'(vcnt), 32'(0));
    tx_word[0] = 8'h3C;
    run_frame(4'b0001, -1, "mr_fresh", lat, gcnt, ecnt);
    chk("mr_fresh_data", 32'(bus.out_data), 32'h3C);
    chk("mr_fresh_src",  32'(bus.out_src),  32'(0));
    drain();

    // Missing done at capture
    kill_done = 1'b1;
    tx_word[3] = 8'h5A;
    bus.req = 4'b1000;
    cyc();
    bus.req = '0;
    vcnt = 0;
    repeat (SIZE + 6) begin cyc(); if (bus.out_valid) vcnt++; end
    chk("md_no_valid", 32'(vcnt), 32'(0));
    chk("md_err",      32'(bus.err), 32'(1));
    kill_done = 1'b0;
    run_frame(4'b1000, -1, "md_next", lat, gcnt, ecnt);
    chk("md_next_data", 32'(bus.out_data), 32'h5A);
    chk("md_next_err",  32'(bus.err),      32'(1));
    drain();

    // req dropped in SHIFT cycle 2
    tx_word[2] = 8'hC3;
    run_frame(4'b0100, 4, "dr", lat, gcnt, ecnt);
    chk("dr_src",  32'(bus.out_src),  32'(2));
    chk("dr_data", 32'(bus.out_data), 32'hC3);
    chk("dr_en",   32'(ecnt),         32'(8));
    drain();

    // Random traffic
    do_reset();
    rand_words = 1'b1;
    for (int i = 0; i < NR; i++) tx_word[i] = SIZE'($urandom);
    repeat (3000) begin
      bus.req       = (($urandom % 4) == 0) ? '0 : NUM_REQ'($urandom);
      bus.out_ready = ($urandom % 10) < 7;
      kill_done     = ($urandom % 20) == 0;
      reset         = ($urandom % 300) == 0;
      cyc();
    end
    reset = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
